cdb_arbiter: RTL and testbench

//  Arbitrates the single common data bus (CDB) between the functional units: LS, ADD1-3, MULT1-2.

---
 rtl/tomasulo_pkg.sv | 26 ++
 rtl/rr_pick.sv | 28 ++
 rtl/cdb_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: producer tags, requester indices and default widths.
// Used by the CDB arbiter and its round-robin picker.
package tomasulo_pkg;

  localparam int NUM_REQ_DEF   = 6;
  localparam int DATA_W_DEF    = 32;
  localparam int TAG_W_DEF     = 4;
  localparam int ROB_IDX_W_DEF = 3;
  localparam int ROB_DEPTH     = 8;

  localparam logic [TAG_W_DEF-1:0] TAG_NONE    = 4'd0;
  localparam logic [TAG_W_DEF-1:0] TAG_LS_BASE = 4'd1;
  localparam logic [TAG_W_DEF-1:0] TAG_ADD1    = 4'd7;
  localparam logic [TAG_W_DEF-1:0] TAG_ADD2    = 4'd8;
  localparam logic [TAG_W_DEF-1:0] TAG_ADD3    = 4'd9;
  localparam logic [TAG_W_DEF-1:0] TAG_MULT1   = 4'd10;
  localparam logic [TAG_W_DEF-1:0] TAG_MULT2   = 4'd11;

  localparam int REQ_LS    = 0;
  localparam int REQ_ADD1  = 1;
  localparam int REQ_ADD2  = 2;
  localparam int REQ_ADD3  = 3;
  localparam int REQ_MULT1 = 4;
  localparam int REQ_MULT2 = 5;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set bit of mask_i at or after start_i
// (wrapping modulo N), returned one-hot together with a found flag.
module rr_pick #(
  parameter int N     = 6,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask_i,
  input  logic [PTR_W-1:0] start_i,
  output logic [N-1:0]     onehot_o,
  output logic             found_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    onehot_o = '0;
    found_o  = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(start_i) + k) % N);
      if (!found_o && mask_i[idx]) begin
        onehot_o[idx] = 1'b1;
        found_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-hot valid/ready grant, registered broadcast, conflict flag.
// Define CDB_OLDEST_FIRST_EN for oldest-ROB-entry-first selection (round-robin tie-break).
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int ROB_IDX_W = ROB_IDX_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]  req_rob,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [ROB_IDX_W-1:0]          rob_head,
  output logic                          cdb_valid,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic [DATA_W-1:0]             cdb_data,
  output logic [ROB_IDX_W-1:0]          cdb_rob_idx,
  output logic                          cdb_conflict
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 cdb_valid_q;
  logic [TAG_W-1:0]     cdb_tag_q;
  logic [DATA_W-1:0]    cdb_data_q;
  logic [ROB_IDX_W-1:0] cdb_rob_q;
  logic                 conflict_q, conflict_d;

  logic [NUM_REQ-1:0]   pick_mask;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic                 pick_found;
  logic [NUM_REQ-1:0]   grant;

`ifdef CDB_OLDEST_FIRST_EN
  logic [ROB_IDX_W-1:0] age [NUM_REQ];
  logic [ROB_IDX_W-1:0] min_age;

  // Age is the modular distance from the ROB head; wrap-around is intentional.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_age
      assign age[gi] = req_rob[gi*ROB_IDX_W +: ROB_IDX_W] - rob_head;
    end
  endgenerate

  always_comb begin
    min_age = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (age[i] < min_age)) min_age = age[i];
    end
  end

  always_comb begin
    pick_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_mask[i] = req_valid[i] && (age[i] == min_age);
    end
  end
`else
  logic unused_rob_head;
  assign unused_rob_head = ^rob_head;
  assign pick_mask       = req_valid;
`endif

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .mask_i   (pick_mask),
    .start_i  (rr_ptr_q),
    .onehot_o (pick_onehot),
    .found_o  (pick_found)
  );

  assign grant     = (rst_n && !flush && pick_found) ? pick_onehot : '0;
  assign req_ready = grant;

  // One-hot grant: OR-reduce the selected slices instead of building a priority mux.
  logic [TAG_W-1:0]     tag_sel;
  logic [DATA_W-1:0]    data_sel;
  logic [ROB_IDX_W-1:0] rob_sel;
  logic [PTR_W-1:0]     win_idx;

  always_comb begin
    tag_sel  = '0;
    data_sel = '0;
    rob_sel  = '0;
    win_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        tag_sel  = tag_sel  | req_tag[i*TAG_W +: TAG_W];
        data_sel = data_sel | req_data[i*DATA_W +: DATA_W];
        rob_sel  = rob_sel  | req_rob[i*ROB_IDX_W +: ROB_IDX_W];
        win_idx  = win_idx  | PTR_W'(i);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (|grant) begin
      rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  assign conflict_d = ($countones(req_valid) > 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_rob_q   <= '0;
      conflict_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= |grant;
      conflict_q  <= conflict_d;
      if (|grant) begin
        cdb_tag_q  <= tag_sel;
        cdb_data_q <= data_sel;
        cdb_rob_q  <= rob_sel;
      end
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_rob_idx  = cdb_rob_q;
  assign cdb_conflict = conflict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: table of per-cycle vectors plus hand sequences
// for reset, single request, oldest-first ordering and reset-over-flush.
module tb_cdb_arbiter;

  localparam int N  = 6;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int RW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N*TW-1:0]   req_tag;
  logic [N*DW-1:0]   req_data;
  logic [N*RW-1:0]   req_rob;
  logic [N-1:0]      req_ready;
  logic [RW-1:0]     rob_head;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic [RW-1:0]     cdb_rob_idx;
  logic              cdb_conflict;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_data     (req_data),
    .req_rob      (req_rob),
    .req_ready    (req_ready),
    .rob_head     (rob_head),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_rob_idx  (cdb_rob_idx),
    .cdb_conflict (cdb_conflict)
  );

  typedef struct packed {
    logic [N-1:0]  valid;
    logic          flush;
    logic [N-1:0]  exp_ready;
    logic          exp_v;
    logic [TW-1:0] exp_tag;
    logic [DW-1:0] exp_data;
    logic [RW-1:0] exp_rob;
    logic          exp_conf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] tags [N];
  logic [DW-1:0] datas[N];
  logic [RW-1:0] robs [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = tags[i];
      req_data[i*DW +: DW] = datas[i];
      req_rob[i*RW +: RW]  = robs[i];
    end
  endtask

  // Inputs are applied 1 time unit after a posedge; ready is sampled 1 unit later,
  // broadcast outputs 1 unit after the following posedge.
  task automatic step(input logic [N-1:0] v, input logic f);
    req_valid = v;
    flush     = f;
    pack_inputs();
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = '0; rob_head = '0;
    req_tag = '0; req_data = '0; req_rob = '0;
    for (int i = 0; i < N; i++) begin
      datas[i] = 32'hA000_0000 | DW'(i);
      robs[i]  = 3'd3;
    end
    tags[0] = 4'd1; tags[1] = 4'd7; tags[2] = 4'd8;
    tags[3] = 4'd9; tags[4] = 4'd10; tags[5] = 4'd11;

    // Reset held two cycles with every requester valid.
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      step(6'b111111, 1'b0);
      chk("reset_ready", 32'(req_ready), 32'h0);
      advance();
      chk("reset_cdb_valid", 32'(cdb_valid), 32'h0);
      chk("reset_conflict", 32'(cdb_conflict), 32'h0);
    end
    rst_n = 1'b1;

    // Single ADD2 request.
    datas[2] = 32'hDEAD_BEEF; robs[2] = 3'd5;
    step(6'b000100, 1'b0);
    chk("single_ready", 32'(req_ready), 32'h04);
    advance();
    chk("single_valid", 32'(cdb_valid), 32'h1);
    chk("single_tag", 32'(cdb_tag), 32'h8);
    chk("single_data", cdb_data, 32'hDEAD_BEEF);
    chk("single_rob", 32'(cdb_rob_idx), 32'h5);
    step(6'b000000, 1'b0);
    advance();
    chk("single_drop", 32'(cdb_valid), 32'h0);
    chk("single_hold", cdb_data, 32'hDEAD_BEEF);
    datas[2] = 32'hA000_0002; robs[2] = 3'd3;

    //            valid      fl  ready      v  tag    data            rob  conf
    vecs[0]  = '{6'b000000, 1'b1, 6'b000000, 1'b0, 4'd8,  32'hDEAD_BEEF, 3'd5, 1'b0};
    vecs[1]  = '{6'b111111, 1'b0, 6'b000001, 1'b1, 4'd1,  32'hA000_0000, 3'd3, 1'b1};
    vecs[2]  = '{6'b111110, 1'b0, 6'b000010, 1'b1, 4'd7,  32'hA000_0001, 3'd3, 1'b1};
    vecs[3]  = '{6'b111100, 1'b0, 6'b000100, 1'b1, 4'd8,  32'hA000_0002, 3'd3, 1'b1};
    vecs[4]  = '{6'b111000, 1'b0, 6'b001000, 1'b1, 4'd9,  32'hA000_0003, 3'd3, 1'b1};
    vecs[5]  = '{6'b110000, 1'b0, 6'b010000, 1'b1, 4'd10, 32'hA000_0004, 3'd3, 1'b1};
    vecs[6]  = '{6'b100000, 1'b0, 6'b100000, 1'b1, 4'd11, 32'hA000_0005, 3'd3, 1'b0};
    vecs[7]  = '{6'b010000, 1'b0, 6'b010000, 1'b1, 4'd10, 32'hA000_0004, 3'd3, 1'b0};
    vecs[8]  = '{6'b100001, 1'b0, 6'b100000, 1'b1, 4'd11, 32'hA000_0005, 3'd3, 1'b1};
    vecs[9]  = '{6'b000001, 1'b0, 6'b000001, 1'b1, 4'd1,  32'hA000_0000, 3'd3, 1'b0};
    vecs[10] = '{6'b000000, 1'b0, 6'b000000, 1'b0, 4'd1,  32'hA000_0000, 3'd3, 1'b0};
    vecs[11] = '{6'b000100, 1'b0, 6'b000100, 1'b1, 4'd8,  32'hA000_0002, 3'd3, 1'b0};
    vecs[12] = '{6'b010000, 1'b1, 6'b000000, 1'b0, 4'd8,  32'hA000_0002, 3'd3, 1'b0};
    vecs[13] = '{6'b010000, 1'b0, 6'b010000, 1'b1, 4'd10, 32'hA000_0004, 3'd3, 1'b0};
    vecs[14] = '{6'b000011, 1'b1, 6'b000000, 1'b0, 4'd10, 32'hA000_0004, 3'd3, 1'b1};
    vecs[15] = '{6'b000010, 1'b0, 6'b000010, 1'b1, 4'd7,  32'hA000_0001, 3'd3, 1'b0};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].valid, vecs[i].flush);
      if (i > 0) chk($sformatf("v%0d_pre_valid", i), 32'(cdb_valid), 32'(vecs[i-1].exp_v));
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      advance();
      chk($sformatf("v%0d_valid", i), 32'(cdb_valid), 32'(vecs[i].exp_v));
      chk($sformatf("v%0d_tag", i), 32'(cdb_tag), 32'(vecs[i].exp_tag));
      chk($sformatf("v%0d_data", i), cdb_data, vecs[i].exp_data);
      chk($sformatf("v%0d_rob", i), 32'(cdb_rob_idx), 32'(vecs[i].exp_rob));
      chk($sformatf("v%0d_conflict", i), 32'(cdb_conflict), 32'(vecs[i].exp_conf));
      $display("vec %0d valid=%b flush=%b ready=%b cdb_v=%b tag=%0d", i,
               vecs[i].valid, vecs[i].flush, req_ready, cdb_valid, cdb_tag);
    end

    // Oldest-first ordering: pointer cleared by a flush first.
    step(6'b000000, 1'b1);
    advance();
    robs[0] = 3'd1; robs[1] = 3'd7; robs[5] = 3'd6; rob_head = 3'd6;
    begin
      logic [N-1:0]  vmask;
      logic [N-1:0]  exp_g [3];
      logic [TW-1:0] exp_t [3];
`ifdef CDB_OLDEST_FIRST_EN
      exp_g[0] = 6'b100000; exp_g[1] = 6'b000010; exp_g[2] = 6'b000001;
      exp_t[0] = 4'd11;     exp_t[1] = 4'd7;      exp_t[2] = 4'd1;
`else
      exp_g[0] = 6'b000001; exp_g[1] = 6'b000010; exp_g[2] = 6'b100000;
      exp_t[0] = 4'd1;      exp_t[1] = 4'd7;      exp_t[2] = 4'd11;
`endif
      vmask = 6'b100011;
      for (int k = 0; k < 3; k++) begin
        step(vmask, 1'b0);
        chk($sformatf("age%0d_ready", k), 32'(req_ready), 32'(exp_g[k]));
        advance();
        chk($sformatf("age%0d_tag", k), 32'(cdb_tag), 32'(exp_t[k]));
        $display("age %0d ready=%b tag=%0d", k, req_ready, cdb_tag);
        vmask = vmask & ~exp_g[k];
      end
    end
    robs[0] = 3'd3; robs[1] = 3'd3; robs[5] = 3'd3; rob_head = 3'd0;

    // Reset and flush together after a grant: reset clears everything.
    step(6'b000100, 1'b0);
    advance();
    rst_n = 1'b0;
    step(6'b111111, 1'b1);
    chk("rstflush_ready", 32'(req_ready), 32'h0);
    advance();
    chk("rstflush_valid", 32'(cdb_valid), 32'h0);
    chk("rstflush_tag", 32'(cdb_tag), 32'h0);
    chk("rstflush_data", cdb_data, 32'h0);
    chk("rstflush_rob", 32'(cdb_rob_idx), 32'h0);
    chk("rstflush_conflict", 32'(cdb_conflict), 32'h0);
    rst_n = 1'b1;
    step(6'b100001, 1'b0);
    chk("post_reset_ptr", 32'(req_ready), 32'h01);
    advance();
    step(6'b000000, 1'b0);
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
